// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, reset PC, fetch state encoding and PC-select codes for the
// instruction fetch unit.
package instruction_fetch_unit_pkg;

   localparam int                        IFU_ADDR_WIDTH = 5;
   localparam int                        IFU_DATA_WIDTH = 8;
   localparam logic [IFU_ADDR_WIDTH-1:0] IFU_RESET_PC   = '0;

   typedef enum logic [1:0] {
      FETCH_IDLE   = 2'd0,
      FETCH_REQ    = 2'd1,
      FETCH_HOLD   = 2'd2,
      FETCH_HALTED = 2'd3
   } fetch_state_e;

   typedef enum logic [1:0] {
      PC_KEEP = 2'd0,
      PC_INC1 = 2'd1,
      PC_INC2 = 2'd2,
      PC_LOAD = 2'd3
   } pc_sel_e;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Next-PC mux: keep, +1, +2 (skip) or jump target; arithmetic wraps at the
// address width.
module instruction_fetch_unit_program_counter
   import instruction_fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = IFU_ADDR_WIDTH
) (
   input  pc_sel_e               sel_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   output logic [ADDR_WIDTH-1:0] pc_next_o
);

   always_comb begin
      pc_next_o = pc_i;
      case (sel_i)
         PC_INC1: pc_next_o = pc_i + ADDR_WIDTH'(1);
         PC_INC2: pc_next_o = pc_i + ADDR_WIDTH'(2);
         PC_LOAD: pc_next_o = load_addr_i;
         default: pc_next_o = pc_i;
      endcase
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, req/ack program-memory read, valid/ready
// delivery to the IR, with jump, skip and halt control.
//
// state        | meaning
// FETCH_IDLE   | between fetches; decides halt or next request
// FETCH_REQ    | mem_req high, waiting for mem_ack
// FETCH_HOLD   | instr_valid high, waiting for instr_ready
// FETCH_HALTED | stopped; only pc_load or reset leaves
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                    ADDR_WIDTH = IFU_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = IFU_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_ack_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] instr_data_o,
   output logic [ADDR_WIDTH-1:0] instr_pc_o,
   input  logic                  instr_ready_i,
   input  logic                  pc_load_i,
   input  logic [ADDR_WIDTH-1:0] pc_load_addr_i,
   input  logic                  pc_skip_i,
   input  logic                  halt_i,
   output logic                  halted_o
);

   fetch_state_e          state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;
   logic                  mem_req_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic                  instr_valid_q;
   logic [DATA_WIDTH-1:0] instr_data_q;
   logic [ADDR_WIDTH-1:0] instr_pc_q;
   logic                  halted_q;
   logic                  squash_q;
   logic                  skip_pending_q;
   pc_sel_e               pc_sel;
   logic                  skip_any;

   always_comb begin
      pc_sel   = PC_KEEP;
      skip_any = skip_pending_q | pc_skip_i;
      case (state_q)
         FETCH_IDLE, FETCH_HOLD: begin
            if (pc_load_i)      pc_sel = PC_LOAD;
            else if (pc_skip_i) pc_sel = PC_INC1;
         end
         FETCH_REQ: begin
            if (pc_load_i) begin
               pc_sel = PC_LOAD;
            end else if (mem_ack_i) begin
               // A squashed fetch already sits at its jump target; only a skip moves it.
               if (squash_q) pc_sel = skip_any ? PC_INC1 : PC_KEEP;
               else          pc_sel = skip_any ? PC_INC2 : PC_INC1;
            end
         end
         FETCH_HALTED: begin
            if (pc_load_i) pc_sel = PC_LOAD;
         end
         default: pc_sel = PC_KEEP;
      endcase
   end

   instruction_fetch_unit_program_counter #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_program_counter (
      .sel_i       (pc_sel),
      .pc_i        (pc_q),
      .load_addr_i (pc_load_addr_i),
      .pc_next_o   (pc_d)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= FETCH_IDLE;
         pc_q           <= RESET_PC;
         mem_req_q      <= 1'b0;
         mem_addr_q     <= RESET_PC;
         instr_valid_q  <= 1'b0;
         instr_data_q   <= '0;
         instr_pc_q     <= '0;
         halted_q       <= 1'b0;
         squash_q       <= 1'b0;
         skip_pending_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         case (state_q)
            FETCH_IDLE: begin
               if (pc_load_i) begin
                  state_q        <= FETCH_REQ;
                  mem_req_q      <= 1'b1;
                  mem_addr_q     <= pc_d;
                  instr_valid_q  <= 1'b0;
                  skip_pending_q <= 1'b0;
               end else if (halt_i) begin
                  state_q  <= FETCH_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  state_q    <= FETCH_REQ;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= pc_d;
               end
            end
            FETCH_REQ: begin
               if (mem_ack_i) begin
                  mem_req_q      <= 1'b0;
                  squash_q       <= 1'b0;
                  skip_pending_q <= 1'b0;
                  if (squash_q || pc_load_i) begin
                     state_q <= FETCH_IDLE;
                  end else begin
                     instr_data_q  <= mem_rdata_i;
                     instr_pc_q    <= pc_q;
                     instr_valid_q <= 1'b1;
                     state_q       <= FETCH_HOLD;
                  end
               end else if (pc_load_i) begin
                  // Memory still owns the old address; keep mem_addr and drop the byte later.
                  squash_q       <= 1'b1;
                  skip_pending_q <= 1'b0;
               end else if (pc_skip_i) begin
                  skip_pending_q <= 1'b1;
               end
            end
            FETCH_HOLD: begin
               if (pc_load_i) begin
                  instr_valid_q  <= 1'b0;
                  skip_pending_q <= 1'b0;
                  state_q        <= FETCH_REQ;
                  mem_req_q      <= 1'b1;
                  mem_addr_q     <= pc_d;
               end else if (instr_valid_q && instr_ready_i) begin
                  instr_valid_q <= 1'b0;
                  if (halt_i) begin
                     state_q  <= FETCH_HALTED;
                     halted_q <= 1'b1;
                  end else begin
                     state_q    <= FETCH_REQ;
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= pc_d;
                  end
               end
            end
            FETCH_HALTED: begin
               if (pc_load_i) begin
                  halted_q       <= 1'b0;
                  skip_pending_q <= 1'b0;
                  state_q        <= FETCH_REQ;
                  mem_req_q      <= 1'b1;
                  mem_addr_q     <= pc_d;
               end
            end
            default: state_q <= FETCH_IDLE;
         endcase
      end
   end

   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = mem_addr_q;
   assign instr_valid_o = instr_valid_q;
   assign instr_data_o  = instr_data_q;
   assign instr_pc_o    = instr_pc_q;
   assign halted_o      = halted_q;

   // Registered outputs track the state one-to-one.
   a_req_in_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
      mem_req_q == (state_q == FETCH_REQ));
   a_valid_in_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
      instr_valid_q == (state_q == FETCH_HOLD));
   a_halted_state : assert property (@(posedge clk_i) disable iff (!rst_ni)
      halted_q == (state_q == FETCH_HALTED));
   a_addr_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (mem_req_q && !mem_ack_i) |=> $stable(mem_addr_q));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit: driver acts as program
// memory and controller, monitor checks every IR handoff against the model queue.
module tb_instruction_fetch_unit;

   localparam int AW = 5;
   localparam int DW = 8;

   localparam int A_NONE      = 0;
   localparam int A_SKIP_REQ  = 1;
   localparam int A_LOAD_REQ  = 2;
   localparam int A_LOAD_ACK  = 3;
   localparam int A_SKIP_HOLD = 4;
   localparam int A_LOAD_HOLD = 5;
   localparam int A_HALT      = 6;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          mem_req_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_ack_i = 1'b0;
   logic [DW-1:0] mem_rdata_i = '0;
   logic          instr_valid_o;
   logic [DW-1:0] instr_data_o;
   logic [AW-1:0] instr_pc_o;
   logic          instr_ready_i = 1'b0;
   logic          pc_load_i = 1'b0;
   logic [AW-1:0] pc_load_addr_i = '0;
   logic          pc_skip_i = 1'b0;
   logic          halt_i = 1'b0;
   logic          halted_o;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [DW-1:0] mem [0:31];
   logic [AW-1:0] model_pc;

   instruction_fetch_unit dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_ack_i      (mem_ack_i),
      .mem_rdata_i    (mem_rdata_i),
      .instr_valid_o  (instr_valid_o),
      .instr_data_o   (instr_data_o),
      .instr_pc_o     (instr_pc_o),
      .instr_ready_i  (instr_ready_i),
      .pc_load_i      (pc_load_i),
      .pc_load_addr_i (pc_load_addr_i),
      .pc_skip_i      (pc_skip_i),
      .halt_i         (halt_i),
      .halted_o       (halted_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: a handoff happens at the next rising edge whenever valid and ready
   // are both high mid-cycle.
   always @(negedge clk_i) begin
      if (rst_ni && instr_valid_o && instr_ready_i) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_delivery: got pc %0h data %0h expected none", instr_pc_o, instr_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("deliver_pc", 32'(instr_pc_o), 32'(mon_e.pc));
            check("deliver_data", 32'(instr_data_o), 32'(mon_e.data));
         end
      end
   end

   task automatic fetch(input int act, input int d_in, input int r_in, input logic [AW-1:0] tgt);
      int            d;
      int            r;
      int            n;
      logic [AW-1:0] exp_pc;
      logic [DW-1:0] data;
      bit            presented;
      d = d_in;
      r = r_in;
      n = 0;
      while (!mem_req_o && n < 20) begin
         step();
         n++;
      end
      if (!mem_req_o) begin
         check("req_timeout", 32'(mem_req_o), 32'd1);
         return;
      end
      check("req_addr", 32'(mem_addr_o), 32'(model_pc));
      exp_pc = model_pc;
      data   = mem[model_pc];
      if ((act == A_SKIP_REQ || act == A_LOAD_REQ) && d < 1) d = 1;
      if ((act == A_SKIP_HOLD || act == A_LOAD_HOLD) && r < 1) r = 1;
      if (act == A_HALT) halt_i = 1'b1;

      for (int k = 0; k < d; k++) begin
         pc_skip_i      = ((act == A_SKIP_REQ) && k < 2) || ((act == A_LOAD_REQ) && k == 0);
         pc_load_i      = (act == A_LOAD_REQ) && k == 0;
         pc_load_addr_i = tgt;
         step();
         pc_skip_i = 1'b0;
         pc_load_i = 1'b0;
         check("req_held", 32'(mem_req_o), 32'd1);
         check("addr_stable", 32'(mem_addr_o), 32'(exp_pc));
      end

      presented = !(act == A_LOAD_REQ || act == A_LOAD_ACK);
      if (presented && act != A_LOAD_HOLD) exp_q.push_back('{pc: exp_pc, data: data});
      mem_ack_i      = 1'b1;
      mem_rdata_i    = mem[mem_addr_o];
      pc_load_i      = (act == A_LOAD_ACK);
      pc_load_addr_i = tgt;
      step();
      mem_ack_i   = 1'b0;
      pc_load_i   = 1'b0;
      mem_rdata_i = DW'($urandom);
      check("valid_after_ack", 32'(instr_valid_o), 32'(presented));
      if (!presented) begin
         model_pc = tgt;
         return;
      end
      model_pc = model_pc + ((act == A_SKIP_REQ) ? AW'(2) : AW'(1));

      for (int k = 0; k < r; k++) begin
         pc_skip_i      = (act == A_SKIP_HOLD || act == A_LOAD_HOLD) && k == 0;
         pc_load_i      = (act == A_LOAD_HOLD) && k == 0;
         pc_load_addr_i = tgt;
         step();
         pc_skip_i = 1'b0;
         pc_load_i = 1'b0;
         if (act == A_LOAD_HOLD) begin
            check("flush_valid", 32'(instr_valid_o), 32'd0);
            model_pc = tgt;
            return;
         end
         check("hold_valid", 32'(instr_valid_o), 32'd1);
         check("hold_data", 32'(instr_data_o), 32'(data));
         check("hold_pc", 32'(instr_pc_o), 32'(exp_pc));
         check("hold_no_req", 32'(mem_req_o), 32'd0);
      end
      if (act == A_SKIP_HOLD) model_pc = model_pc + AW'(1);

      instr_ready_i = 1'b1;
      step();
      instr_ready_i = 1'b0;
      check("valid_drop", 32'(instr_valid_o), 32'd0);

      if (act == A_HALT) begin
         check("halted", 32'(halted_o), 32'd1);
         n = 0;
         for (int k = 0; k < 20; k++) begin
            if (mem_req_o || instr_valid_o || !halted_o) n++;
            step();
         end
         check("halt_quiet", 32'(n), 32'd0);
         halt_i         = 1'b0;
         pc_load_i      = 1'b1;
         pc_load_addr_i = tgt;
         step();
         pc_load_i = 1'b0;
         check("resume_halted", 32'(halted_o), 32'd0);
         model_pc = tgt;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int act;
      logic [AW-1:0] tgt;
      for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
      mem[0]   = 8'hA5;
      model_pc = '0;

      repeat (3) @(posedge clk_i);
      #1;
      check("rst_mem_req", 32'(mem_req_o), 32'd0);
      check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_data", 32'(instr_data_o), 32'd0);
      check("rst_pc", 32'(instr_pc_o), 32'd0);
      check("rst_halted", 32'(halted_o), 32'd0);
      #2 rst_ni = 1'b1;

      fetch(A_NONE, 2, 0, '0);
      fetch(A_NONE, 1, 5, '0);
      fetch(A_LOAD_HOLD, 0, 1, 5'd31);
      fetch(A_NONE, 1, 0, '0);
      fetch(A_LOAD_HOLD, 0, 1, 5'd31);
      fetch(A_SKIP_REQ, 1, 0, '0);
      fetch(A_LOAD_REQ, 2, 0, 5'h10);
      fetch(A_NONE, 0, 0, '0);
      fetch(A_LOAD_HOLD, 0, 1, 5'd3);
      fetch(A_SKIP_HOLD, 0, 2, '0);
      fetch(A_LOAD_ACK, 1, 0, 5'd7);
      fetch(A_HALT, 1, 0, 5'd2);
      fetch(A_NONE, 0, 0, '0);

      for (int i = 0; i < 300; i++) begin
         act = int'($urandom_range(0, 6));
         tgt = ($urandom_range(0, 3) == 0) ? 5'd31 : AW'($urandom_range(0, 31));
         fetch(act, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), tgt);
      end

      // Asynchronous reset in the middle of an outstanding request.
      n = 0;
      while (!mem_req_o && n < 20) begin
         step();
         n++;
      end
      check("pre_reset_req", 32'(mem_req_o), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      check("async_rst_req", 32'(mem_req_o), 32'd0);
      check("async_rst_valid", 32'(instr_valid_o), 32'd0);
      check("async_rst_addr", 32'(mem_addr_o), 32'd0);
      halt_i = 1'b1;
      #3 rst_ni = 1'b1;
      step();
      step();
      check("idle_halt", 32'(halted_o), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      check("async_rst_halted", 32'(halted_o), 32'd0);
      halt_i = 1'b0;
      #3 rst_ni = 1'b1;
      model_pc = '0;

      for (int i = 0; i < 4; i++) fetch(A_NONE, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), '0);

      repeat (2) step();
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
